moving_average_sequencer: RTL and testbench
===========================================

// Module: moving_average_sequencer
// PURPOSE
// - Sequences a DEPTH-sample moving-average filter for the TT display/counter design.
// - Owns the sample-rate prescaler and the capture/read-oldest/write-new/update sequence.
// - The sample window lives in an external 1-read-latency RAM.
// - Keeps a running sum and emits avg_out with a one-cycle avg_valid strobe per sample.
// PARAMETERS
// - WIDTH      8              sample and average width (bits)
// - DEPTH_LOG2 3              log2 of window length; DEPTH = 2**DEPTH_LOG2 = 8
// - MAX_COUNT  24'd10_000_000 prescaler compare value used when rate_sel == 0
// PORTS
// - clk          in   1             system clock, all logic on posedge
// - reset        in   1             synchronous, active-high; clears all state
// - ena          in   1             1 = prescaler runs; 0 = prescaler holds, in-flight op completes
// - rate_sel     in   8             0 -> compare = MAX_COUNT; else compare = {6'b0, rate_sel, 10'b0}
// - clear        in   1             sync flush: sum, fill, pointer to 0; aborts in-flight op
// - sample_in    in   WIDTH         sample, captured on the tick cycle
// - buf_addr     out  DEPTH_LOG2    window RAM address (= wr_ptr)
// - buf_re       out  1             RAM read enable; buf_rdata is valid the following cycle
// - buf_we       out  1             RAM write enable
// - buf_wdata    out  WIDTH         RAM write data (captured sample)
// - buf_rdata    in   WIDTH         RAM read data
// - tick         out  1             one-cycle pulse when the prescaler reaches compare
// - busy         out  1             high while the FSM is in RD or UPD
// - avg_out      out  WIDTH         current average, held between updates
// - avg_valid    out  1             one-cycle pulse when avg_out updates
// - fill_count   out  DEPTH_LOG2+1  samples in window, saturates at DEPTH
// - overrun      out  1             sticky: a tick was dropped because busy was high
// BEHAVIOUR
// - Reset values: every output and internal register is 0; FSM is in IDLE.
// - Prescaler: 24-bit counter cnt, increments only while ena = 1.
//   - When cnt >= compare: cnt <= 0 and tick = 1. Period is compare+1 cycles.
//   - The >= compare means lowering rate_sel below the current cnt ticks on the next enabled cycle (no 2^24 wrap).
// - FSM, for a tick at cycle T:
//   - IDLE: on tick, sample_q <= sample_in; go to RD.
//   - RD (T+1): buf_re = 1, buf_addr = wr_ptr.
//   - UPD (T+2): old = (fill_count == DEPTH) ? buf_rdata : 0.
//     - sum <= sum + sample_q - old.
//     - buf_we = 1, buf_addr = wr_ptr, buf_wdata = sample_q.
//     - wr_ptr <= wr_ptr + 1, wrapping mod DEPTH.
//     - fill_count <= min(fill_count + 1, DEPTH).
//   - T+3, back in IDLE: avg_out <= sum >> DEPTH_LOG2 (new sum); avg_valid = 1 for exactly this cycle.
// - Latency: tick -> avg_valid is 3 cycles. busy = 1 on T+1 and T+2.
// - Arithmetic: sum is WIDTH+DEPTH_LOG2 bits and never overflows. Warm-up is zero-filled (divide by DEPTH always).
// - Tick while busy: sample dropped, FSM unaffected, overrun <= 1 until reset.
//   - clear does not clear overrun.
// - clear:
//   - sum, wr_ptr, fill_count <= 0; FSM -> IDLE.
//   - In-flight op is aborted: no buf_we, no avg_valid.
//   - avg_out keeps its value.
//   - Has priority over a tick in the same cycle; that tick is ignored and not counted as overrun.
//   - RAM contents are not erased. Stale data is masked because old is 0 until fill_count == DEPTH.
// - reset has priority over clear and everything else.
// - ena = 0: no new ticks; an op already in RD/UPD runs to completion.
// CONFIGURATION
// - MOVAVG_ROUND_EN defined:   avg_out = (sum + 2**(DEPTH_LOG2-1)) >> DEPTH_LOG2.
//   - Adder is WIDTH+DEPTH_LOG2+1 bits; result saturates at 2**WIDTH-1.
// - MOVAVG_ROUND_EN undefined: avg_out = sum >> DEPTH_LOG2 (truncate).
// - All other behaviour is identical in both builds.
// TESTING
// - Reset: assert reset 2 cycles -> all outputs 0.
//   - Then first tick occurs after MAX_COUNT+1 enabled cycles.
// - MAX_COUNT=15, rate_sel=0, sample_in=80: tick every 16 cycles; avg_valid 3 cycles after each tick.
//   - avg_out = 10,20,...,80, then stays 80; fill_count saturates at 8.
// - Continue with sample_in=0 after window full: avg_out = 70,60,...,0.
//   - buf_addr wraps 7 -> 0.
// - rate_sel=1: tick period 1025 cycles.
//   - With cnt=800, switch rate_sel from 1 to 8'h00 with MAX_COUNT=15 -> tick on next cycle, then period 16.
// - clear during RD:
//   - No buf_we, no avg_valid; sum=0, fill_count=0.
//   - Next sample 40 -> avg_out=5.
// - MAX_COUNT=1 with ena=1 -> ticks while busy, overrun=1 (sticky through clear).
// - Rounding check: single sample 4 after clear -> avg_out=0 with MOVAVG_ROUND_EN undefined, 1 with it defined.

Source files
------------

// File: rtl/moving_average_sequencer.sv
// Moving-average sequencer: prescaled sample tick, read-oldest/write-new over a 1-latency window RAM, running sum.
// Optional MOVAVG_ROUND_EN rounds the average instead of truncating; tick -> avg_valid is 3 cycles.
module moving_average_sequencer #(
  parameter int          WIDTH      = 8,
  parameter int          DEPTH_LOG2 = 3,
  parameter logic [23:0] MAX_COUNT  = 24'd10_000_000
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic                  ena,
  input  logic [7:0]            rate_sel,
  input  logic                  clear,
  input  logic [WIDTH-1:0]      sample_in,
  output logic [DEPTH_LOG2-1:0] buf_addr,
  output logic                  buf_re,
  output logic                  buf_we,
  output logic [WIDTH-1:0]      buf_wdata,
  input  logic [WIDTH-1:0]      buf_rdata,
  output logic                  tick,
  output logic                  busy,
  output logic [WIDTH-1:0]      avg_out,
  output logic                  avg_valid,
  output logic [DEPTH_LOG2:0]   fill_count,
  output logic                  overrun
);

  localparam int SUM_W = WIDTH + DEPTH_LOG2;
  localparam logic [DEPTH_LOG2:0] FULL = (DEPTH_LOG2 + 1)'(1 << DEPTH_LOG2);

  typedef enum logic [1:0] {IDLE, RD, UPD} state_t;

  state_t                state;
  logic [23:0]           cnt;
  logic [23:0]           compare;
  logic [WIDTH-1:0]      sample_q;
  logic [SUM_W-1:0]      sum;
  logic [SUM_W-1:0]      sum_next;
  logic [DEPTH_LOG2-1:0] wr_ptr;
  logic [WIDTH-1:0]      old_sample;
  logic [WIDTH-1:0]      avg_next;

  assign compare = (rate_sel == 8'd0) ? MAX_COUNT : {6'b0, rate_sel, 10'b0};
  // >= rather than == so a lowered compare value ticks at once instead of wrapping
  assign tick    = ena && (cnt >= compare);

  assign busy      = (state != IDLE);
  assign buf_addr  = wr_ptr;
  assign buf_re    = (state == RD);
  assign buf_we    = (state == UPD) && !clear;
  assign buf_wdata = sample_q;

  // Stale RAM contents after a clear are masked until the window has refilled
  assign old_sample = (fill_count == FULL) ? buf_rdata : '0;
  assign sum_next   = sum + SUM_W'(sample_q) - SUM_W'(old_sample);

`ifdef MOVAVG_ROUND_EN
  localparam logic [SUM_W:0] HALF = (SUM_W + 1)'(1 << (DEPTH_LOG2 - 1));
  logic [WIDTH:0] rounded;
  assign rounded  = (WIDTH + 1)'(({1'b0, sum_next} + HALF) >> DEPTH_LOG2);
  assign avg_next = rounded[WIDTH] ? '1 : rounded[WIDTH-1:0];
`else
  assign avg_next = WIDTH'(sum_next >> DEPTH_LOG2);
`endif

  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      cnt        <= '0;
      sample_q   <= '0;
      sum        <= '0;
      wr_ptr     <= '0;
      fill_count <= '0;
      avg_out    <= '0;
      avg_valid  <= 1'b0;
      overrun    <= 1'b0;
    end else begin
      if (ena) cnt <= tick ? 24'd0 : cnt + 24'd1;
      avg_valid <= 1'b0;
      if (clear) begin
        state      <= IDLE;
        sum        <= '0;
        wr_ptr     <= '0;
        fill_count <= '0;
      end else begin
        if (tick && busy) overrun <= 1'b1;
        case (state)
          IDLE: begin
            if (tick) begin
              sample_q <= sample_in;
              state    <= RD;
            end
          end
          RD: state <= UPD;
          UPD: begin
            sum        <= sum_next;
            wr_ptr     <= wr_ptr + 1'b1;
            fill_count <= (fill_count == FULL) ? FULL : fill_count + 1'b1;
            avg_out    <= avg_next;
            avg_valid  <= 1'b1;
            state      <= IDLE;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_moving_average_sequencer.sv
// Bench for moving_average_sequencer: table of window-fill vectors, directed corner sequences, random samples vs a queue model.
module tb_moving_average_sequencer;

  logic       clk = 1'b0;
  logic       reset, ena, clear;
  logic [7:0] rate_sel, sample_in;
  logic [2:0] buf_addr;
  logic       buf_re, buf_we;
  logic [7:0] buf_wdata, buf_rdata;
  logic       tick, busy, avg_valid, overrun;
  logic [7:0] avg_out;
  logic [3:0] fill_count;

  logic       f_reset, f_ena, f_clear;
  logic [7:0] f_rate_sel, f_sample_in, f_rdata;
  logic [2:0] f_addr;
  logic       f_re, f_we, f_tick, f_busy, f_valid, f_overrun;
  logic [7:0] f_wdata, f_avg;
  logic [3:0] f_fill;

  logic [7:0] mem [8];

  int checks = 0;
  int errors = 0;
  int win[$];
  int writes = 0;

  always #5 clk = ~clk;

  moving_average_sequencer #(.WIDTH(8), .DEPTH_LOG2(3), .MAX_COUNT(24'd15)) dut (
    .clk(clk), .reset(reset), .ena(ena), .rate_sel(rate_sel), .clear(clear),
    .sample_in(sample_in), .buf_addr(buf_addr), .buf_re(buf_re), .buf_we(buf_we),
    .buf_wdata(buf_wdata), .buf_rdata(buf_rdata), .tick(tick), .busy(busy),
    .avg_out(avg_out), .avg_valid(avg_valid), .fill_count(fill_count), .overrun(overrun)
  );

  moving_average_sequencer #(.WIDTH(8), .DEPTH_LOG2(3), .MAX_COUNT(24'd1)) u_fast (
    .clk(clk), .reset(f_reset), .ena(f_ena), .rate_sel(f_rate_sel), .clear(f_clear),
    .sample_in(f_sample_in), .buf_addr(f_addr), .buf_re(f_re), .buf_we(f_we),
    .buf_wdata(f_wdata), .buf_rdata(f_rdata), .tick(f_tick), .busy(f_busy),
    .avg_out(f_avg), .avg_valid(f_valid), .fill_count(f_fill), .overrun(f_overrun)
  );

  // Window RAM with one cycle of read latency
  always @(posedge clk) begin
    if (buf_we) mem[buf_addr] <= buf_wdata;
    if (buf_re) buf_rdata <= mem[buf_addr];
  end

  task automatic check(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d", name, act, exp);
    end
  endtask

  // Reference: last eight samples, zero-filled, always divided by eight
  task automatic model_push(input int s, output int avg, output int fill, output int addr);
    int sum;
    win.push_back(s);
    if (win.size() > 8) win.delete(0);
    sum = 0;
    foreach (win[i]) sum += win[i];
`ifdef MOVAVG_ROUND_EN
    avg = (sum + 4) / 8;
    if (avg > 255) avg = 255;
`else
    avg = sum / 8;
`endif
    fill = win.size();
    addr = writes % 8;
    writes++;
  endtask

  task automatic model_clear();
    win.delete();
    writes = 0;
  endtask

  // Returns with tick high in the current cycle, n = cycles waited
  task automatic wait_tick(input int limit, input bit rnd, output int n);
    bit ok;
    n = 0;
    ok = 1'b0;
    while (n <= limit) begin
      if (rnd) ena = ($urandom_range(0, 3) != 0);
      #1;
      if (tick) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk); #1;
      n++;
    end
    if (!ok) begin
      errors++;
      $display("FAIL tick_timeout waited=%0d limit=%0d", n, limit);
    end
  endtask

  task automatic op_checks(input int s, input int ea, input int ef, input int eaddr, input bit rnd);
    @(posedge clk); #1; if (rnd) ena = $urandom_range(0, 1); #1;
    check("rd_buf_re", buf_re, 1);
    check("rd_busy", busy, 1);
    check("rd_addr", buf_addr, eaddr);
    check("rd_no_we", buf_we, 0);
    @(posedge clk); #1; if (rnd) ena = $urandom_range(0, 1); #1;
    check("upd_we", buf_we, 1);
    check("upd_addr", buf_addr, eaddr);
    check("upd_wdata", buf_wdata, s);
    check("upd_busy", busy, 1);
    @(posedge clk); #1; if (rnd) ena = $urandom_range(0, 1); #1;
    check("avg_valid", avg_valid, 1);
    check("avg_out", avg_out, ea);
    check("fill_count", fill_count, ef);
    check("idle_busy", busy, 0);
    @(posedge clk); #1; if (rnd) ena = $urandom_range(0, 1); #1;
    check("valid_pulse", avg_valid, 0);
    check("avg_held", avg_out, ea);
  endtask

  typedef struct {
    int sample;
    int avg;
    int fill;
    int addr;
  } vec_t;

  initial begin
    vec_t tbl[16];
    int n, ea, ef, eaddr;

    for (int i = 0; i < 8; i++) begin
      tbl[i]     = '{sample: 80, avg: 10 * (i + 1), fill: i + 1, addr: i};
      tbl[i + 8] = '{sample: 0,  avg: 70 - 10 * i,  fill: 8,     addr: i};
    end
    for (int i = 0; i < 8; i++) mem[i] = 8'd0;
    buf_rdata = 8'd0;

    reset = 1; ena = 0; clear = 0; rate_sel = 0; sample_in = 8'd80;
    f_reset = 1; f_ena = 0; f_clear = 0; f_rate_sel = 0; f_sample_in = 8'd7; f_rdata = 8'd0;

    repeat (2) @(posedge clk);
    #1;
    check("rst_avg_out", avg_out, 0);
    check("rst_avg_valid", avg_valid, 0);
    check("rst_fill", fill_count, 0);
    check("rst_busy", busy, 0);
    check("rst_bus", {buf_re, buf_we, buf_addr, buf_wdata}, 0);
    check("rst_tick_overrun", {tick, overrun}, 0);

    reset = 0; ena = 1;
    wait_tick(40, 0, n);
    check("first_tick_delay", n, 15);

    // Fill the window with 80s, then drain with 0s (pointer wraps 7 -> 0)
    for (int i = 0; i < 16; i++) begin
      sample_in = tbl[i].sample[7:0];
      if (i != 0) begin
        wait_tick(40, 0, n);
        check("period16", n, 12);
      end
      model_push(tbl[i].sample, ea, ef, eaddr);
      op_checks(tbl[i].sample, tbl[i].avg, tbl[i].fill, tbl[i].addr, 0);
    end

    // rate_sel = 1 -> period 1025
    rate_sel = 8'd1; sample_in = 8'd33;
    wait_tick(1100, 0, n);
    check("period1025", n, 1021);
    model_push(33, ea, ef, eaddr);
    op_checks(33, ea, ef, eaddr, 0);
    repeat (797) begin @(posedge clk); #1; end
    #1;
    check("no_tick_cnt800", tick, 0);
    rate_sel = 8'd0; sample_in = 8'd55;
    #1;
    check("tick_after_rate_drop", tick, 1);
    model_push(55, ea, ef, eaddr);
    op_checks(55, ea, ef, eaddr, 0);
    sample_in = 8'd66;
    wait_tick(40, 0, n);
    check("period16_after_drop", n, 12);
    model_push(66, ea, ef, eaddr);
    op_checks(66, ea, ef, eaddr, 0);

    // Random samples with ena toggling, including during in-flight ops
    for (int k = 0; k < 24; k++) begin
      int s;
      s = $urandom_range(0, 255);
      sample_in = s[7:0];
      wait_tick(300, 1, n);
      model_push(s, ea, ef, eaddr);
      op_checks(s, ea, ef, eaddr, 1);
    end
    ena = 1;

    // clear coincident with tick: tick ignored, no overrun
    sample_in = 8'd99;
    wait_tick(40, 0, n);
    clear = 1;
    @(posedge clk); #1; clear = 0; #1;
    check("clr_tick_busy", busy, 0);
    check("clr_tick_overrun", overrun, 0);
    check("clr_tick_fill", fill_count, 0);
    model_clear();

    // clear during RD aborts the op
    sample_in = 8'd200;
    wait_tick(40, 0, n);
    @(posedge clk); #2;
    check("clr_rd_busy_before", busy, 1);
    clear = 1;
    @(posedge clk); #1; clear = 0; #1;
    check("clr_rd_no_we", buf_we, 0);
    check("clr_rd_idle", busy, 0);
    check("clr_rd_fill", fill_count, 0);
    @(posedge clk); #2;
    check("clr_rd_no_valid", avg_valid, 0);
    model_clear();
    sample_in = 8'd40;
    wait_tick(40, 0, n);
    model_push(40, ea, ef, eaddr);
    op_checks(40, ea, ef, eaddr, 0);
    check("after_clear_avg5", avg_out, 5);

    // Idle clear keeps avg_out; single 4 exposes rounding mode
    clear = 1;
    @(posedge clk); #1; clear = 0; #1;
    check("clear_keeps_avg", avg_out, 5);
    check("clear_fill", fill_count, 0);
    model_clear();
    sample_in = 8'd4;
    wait_tick(40, 0, n);
    model_push(4, ea, ef, eaddr);
    op_checks(4, ea, ef, eaddr, 0);
`ifdef MOVAVG_ROUND_EN
    check("round_single4", avg_out, 1);
`else
    check("trunc_single4", avg_out, 0);
`endif
    check("main_no_overrun", overrun, 0);

    // MAX_COUNT=1 instance: ticks arrive while busy
    @(posedge clk); #1;
    f_reset = 0; f_ena = 1; #1;
    check("fast_overrun_init", f_overrun, 0);
    repeat (10) begin @(posedge clk); #1; end
    check("fast_overrun_set", f_overrun, 1);
    f_clear = 1;
    @(posedge clk); #1; f_clear = 0; #1;
    check("fast_overrun_sticky", f_overrun, 1);
    check("fast_clear_fill", f_fill, 0);
    f_reset = 1;
    @(posedge clk); #2;
    check("fast_overrun_reset", f_overrun, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
